rbcount_checker: RTL and testbench

RBCOUNT_CHECKER -- requirements
Module: rbcount_checker

---
 rtl/rbcount_checker.sv | 98 +++++++++
 tb/tb_rbcount_checker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rbcount_checker.sv
// Monitors an upstream 4-bit toggle counter with true/complement outputs.
// Flags complement and sequence errors, counts wraps and errored cycles.
module rbcount_checker #(
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  input  logic [3:0]        q,
  input  logic [3:0]        qb,
  input  logic              clr_err,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err_compl,
  output logic              err_seq,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSync  = 2'd1,
    StTrack = 2'd2,
    StFault = 2'd3
  } state_e;

  state_e             r_state;
  logic [3:0]         r_q_prev;
  logic               r_t_d;
  logic               r_wrap_pulse;
  logic [WRAP_W-1:0]  r_wrap_cnt;
  logic               r_err_compl;
  logic               r_err_seq;
  logic [ERR_W-1:0]   r_err_cnt;

  logic       w_checking;
  logic [3:0] w_q_exp;
  logic       w_compl_err;
  logic       w_seq_err;
  logic       w_any_err;
  logic       w_wrap;

  // Sequence and wrap checks need a q_prev captured in a checking state.
  assign w_checking  = (r_state == StTrack) || (r_state == StFault);
  assign w_q_exp     = r_q_prev + {3'b000, r_t_d};
  assign w_compl_err = (qb != ~q);
  assign w_seq_err   = w_checking && (q != w_q_exp);
  assign w_any_err   = w_compl_err || w_seq_err;
  assign w_wrap      = w_checking && (r_q_prev == 4'hF) && r_t_d && (q == 4'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_q_prev     <= 4'h0;
      r_t_d        <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_wrap_cnt   <= '0;
      r_err_compl  <= 1'b0;
      r_err_seq    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_wrap_pulse <= 1'b0;
      if (r_state == StIdle) begin
        r_state <= StSync;
      end else begin
        r_q_prev <= q;
        r_t_d    <= t;
        if (w_wrap) begin
          r_wrap_pulse <= 1'b1;
          r_wrap_cnt   <= r_wrap_cnt + WRAP_W'(1);
        end
        // A clear wins over anything detected on the same edge.
        if (clr_err) begin
          r_err_compl <= 1'b0;
          r_err_seq   <= 1'b0;
          r_err_cnt   <= '0;
          r_state     <= StSync;
        end else if (w_any_err) begin
          if (w_compl_err) r_err_compl <= 1'b1;
          if (w_seq_err)   r_err_seq   <= 1'b1;
          if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + ERR_W'(1);
          r_state <= StFault;
        end else if (r_state == StSync) begin
          r_state <= StTrack;
        end
      end
    end
  end

  assign wrap_pulse = r_wrap_pulse;
  assign wrap_cnt   = r_wrap_cnt;
  assign err_compl  = r_err_compl;
  assign err_seq    = r_err_seq;
  assign err_cnt    = r_err_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_rbcount_checker.sv
// Directed, table-driven bench for rbcount_checker with hand-computed expectations.
module tb_rbcount_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t = 1'b0;
  logic [3:0] q = 4'h0;
  logic [3:0] qb = 4'hF;
  logic       clr_err = 1'b0;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       err_compl;
  logic       err_seq;
  logic [7:0] err_cnt;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  rbcount_checker dut (
    .clk        (clk),
    .rst        (rst),
    .t          (t),
    .q          (q),
    .qb         (qb),
    .clr_err    (clr_err),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .err_compl  (err_compl),
    .err_seq    (err_seq),
    .err_cnt    (err_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       t;
    logic [3:0] q;
    logic [3:0] x;   // xor applied to ~q to form qb
    int         st;
    int         wp;
    int         wc;
    int         ec;
    int         es;
    int         cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic c, input logic tt,
                       input logic [3:0] qq, input logic [3:0] x);
    rst     = r;
    clr_err = c;
    t       = tt;
    q       = qq;
    qb      = ~qq ^ x;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int wp, input int wc,
                         input int ec, input int es, input int cnt);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".wrap_pulse"}, int'(wrap_pulse), wp);
    chk({tag, ".wrap_cnt"}, int'(wrap_cnt), wc);
    chk({tag, ".err_compl"}, int'(err_compl), ec);
    chk({tag, ".err_seq"}, int'(err_seq), es);
    chk({tag, ".err_cnt"}, int'(err_cnt), cnt);
  endtask

  initial begin
    //            rst clr t  q      x      st wp wc ec es cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd5,  4'd0, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'd5,  4'd0, 2, 0, 0, 0, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'd6,  4'd0, 2, 0, 0, 0, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd7,  4'd0, 2, 0, 0, 0, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd7,  4'd0, 2, 0, 0, 0, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd8,  4'd1, 3, 0, 0, 1, 0, 1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'd9,  4'd0, 1, 0, 0, 0, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd10, 4'd0, 2, 0, 0, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'd5,  4'd0, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd5,  4'd0, 2, 0, 0, 0, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd7,  4'd0, 3, 0, 0, 0, 1, 1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd7,  4'd0, 3, 0, 0, 0, 1, 1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 4'd8,  4'd0, 3, 0, 0, 0, 1, 2};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 4'd10, 4'd4, 3, 0, 0, 1, 1, 3};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 4'd10, 4'd4, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst, vecs[i].clr, vecs[i].t, vecs[i].q, vecs[i].x);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].wp, vecs[i].wc,
              vecs[i].ec, vecs[i].es, vecs[i].cnt);
    end

    // Legal free-running counter from q=0: single wrap when q returns to 0.
    apply(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    chk_all("cnt_rst", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b0, 1'b1, 4'(i % 16), 4'd0);
      chk($sformatf("cnt%0d.state", i), int'(state), (i == 0) ? 1 : 2);
      chk($sformatf("cnt%0d.wrap_pulse", i), int'(wrap_pulse), (i == 16) ? 1 : 0);
      chk($sformatf("cnt%0d.wrap_cnt", i), int'(wrap_cnt), (i >= 16) ? 1 : 0);
    end
    chk("cnt_end.err_cnt", int'(err_cnt), 0);
    chk("cnt_end.err_compl", int'(err_compl), 0);

    // Clear coinciding with a complement error; wrap_cnt must survive.
    apply(1'b0, 1'b0, 1'b1, 4'd4, 4'd1);
    chk_all("clr_pre", 3, 0, 1, 1, 0, 1);
    apply(1'b0, 1'b1, 1'b1, 4'd5, 4'd8);
    chk_all("clr_hit", 1, 0, 1, 0, 0, 0);
    apply(1'b0, 1'b0, 1'b1, 4'd6, 4'd0);
    chk_all("clr_post", 2, 0, 1, 0, 0, 0);

    // 300 bad cycles: err_cnt saturates at 255; wraps still counted in FAULT.
    for (int i = 0; i < 300; i++) begin
      apply(1'b0, 1'b0, 1'b1, 4'((7 + i) % 16), 4'd1);
      if (i == 0)   chk("sat0.err_cnt", int'(err_cnt), 1);
      if (i == 253) chk("sat253.err_cnt", int'(err_cnt), 254);
      if (i == 254) chk("sat254.err_cnt", int'(err_cnt), 255);
    end
    chk_all("sat_end", 3, 0, 20, 1, 0, 255);

    apply(1'b1, 1'b0, 1'b1, 4'd3, 4'd1);
    chk_all("mid_rst", 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
